wb_write_arbiter: RTL

Shares the single register-file write port between the pipeline writeback stage and a late-result source (multi-cycle units returning results after their instruction has left the pipe). Pipeline writes have priority. Late results wait in a small FIFO. A starvation counter briefly stalls the pipe so buffered results always drain. The block sits between writeback and the register file, and exports a pending-write mask to decode for hazard stalls.

---
 rtl/wb_write_arbiter_pkg.sv | 27 ++
 rtl/wb_write_arbiter_if.sv | 37 +++
 rtl/wb_write_arbiter_late_fifo.sv | 79 +++++++
 rtl/wb_write_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package wb_arb_pkg;

  localparam int REG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_arb_state_t;

  // "reg" is a keyword, so the destination field is named regIdx.
  typedef struct packed {
    logic [REG_W-1:0]  regIdx;
    logic [DATA_W-1:0] data;
  } late_entry_t;

  // One-hot decode of a register index, used to build the pending-write mask.
  function automatic logic [NUM_REGS-1:0] regOneHot(input logic [REG_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between writeback, the late-result source, decode and the register file.
interface wb_write_arbiter_if;
  import wb_arb_pkg::*;

  logic                pipe_we;
  logic [REG_W-1:0]    pipe_reg;
  logic [DATA_W-1:0]   pipe_data;
  logic                late_valid;
  logic                late_ready;
  logic [REG_W-1:0]    late_reg;
  logic [DATA_W-1:0]   late_data;
  logic                rf_we;
  logic [REG_W-1:0]    rf_reg;
  logic [DATA_W-1:0]   rf_data;
  logic                pipe_stall;
  logic [NUM_REGS-1:0] pend_mask;
  logic                empty;

  // Environment side: writeback, late source, decode and register file.
  modport master (
    output pipe_we, pipe_reg, pipe_data,
    output late_valid, late_reg, late_data,
    input  late_ready,
    input  rf_we, rf_reg, rf_data,
    input  pipe_stall, pend_mask, empty
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_reg, pipe_data,
    input  late_valid, late_reg, late_data,
    output late_ready,
    output rf_we, rf_reg, rf_data,
    output pipe_stall, pend_mask, empty
  );

endinterface

// File: rtl/wb_write_arbiter_late_fifo.sv
// Late-result FIFO: in-order storage with a per-entry valid vector so the
// top level can publish which registers still have a write in flight.
module wb_late_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  late_entry_t                   din,
  output late_entry_t                   dout,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH-1:0]              entryValid,
  output logic [DEPTH-1:0][REG_W-1:0]   entryReg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  late_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_CNT);
  assign doPop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  // Entry storage; data needs no reset because validity is tracked separately.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (doPop) begin
        rdPtr             <= rdPtr + PTR_W'(1);
        entryValid[rdPtr] <= 1'b0;
      end
      // Set after the clear so a full push+pop on the same slot stays valid.
      if (doPush) begin
        wrPtr             <= wrPtr + PTR_W'(1);
        entryValid[wrPtr] <= 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Expose each slot's destination register for the pending-write mask.
  always_comb begin
    entryReg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryReg[i] = mem[i].regIdx;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, late results queue
// in a FIFO, and a starvation counter forces one head grant when needed.
//
//   state  | meaning
//   NORMAL | pipe has priority; FIFO head granted only on idle pipe cycles
//   FORCE  | pipe stalled for one cycle; FIFO head granted unconditionally
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.slave  bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [WAIT_W-1:0] wait_t;
  localparam cnt_t  DEPTH_CNT = cnt_t'(DEPTH);
  localparam wait_t WAIT_MAX  = wait_t'(STARVE_LIMIT);

  wb_arb_state_t              state;
  wb_arb_state_t              stateNext;
  wait_t                      waitCnt;
  wait_t                      waitNext;
  logic                       pipeGrant;
  logic                       headGrant;
  logic                       push;
  late_entry_t                pushEntry;
  late_entry_t                headEntry;
  cnt_t                       fifoCount;
  logic                       fifoEmpty;
  logic                       fifoFull;
  logic [DEPTH-1:0]           entryValid;
  logic [DEPTH-1:0][REG_W-1:0] entryReg;
  logic [NUM_REGS-1:0]        pendMask;
  logic                       rfWe;
  logic [REG_W-1:0]           rfReg;
  logic [DATA_W-1:0]          rfData;

  assign pushEntry.regIdx = bus.late_reg;
  assign pushEntry.data   = bus.late_data;
  assign push             = bus.late_valid && !fifoFull;

  wb_late_fifo #(.DEPTH(DEPTH)) lateFifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (headGrant),
    .din        (pushEntry),
    .dout       (headEntry),
    .count      (fifoCount),
    .empty      (fifoEmpty),
    .full       (fifoFull),
    .entryValid (entryValid),
    .entryReg   (entryReg)
  );

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= NORMAL;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
    end
  end

  // Grant selection, starvation count update and next-state decode.
  always_comb begin
    stateNext = state;
    waitNext  = waitCnt;
    pipeGrant = 1'b0;
    headGrant = 1'b0;

    case (state)
      NORMAL: begin
        pipeGrant = bus.pipe_we;
        headGrant = !bus.pipe_we && !fifoEmpty;
      end
      FORCE: begin
        headGrant = !fifoEmpty;
      end
    endcase

    if (fifoEmpty || headGrant) begin
      waitNext = '0;
    end else if (waitCnt != WAIT_MAX) begin
      waitNext = waitCnt + wait_t'(1);
    end

    case (state)
      NORMAL: if (waitNext == WAIT_MAX) stateNext = FORCE;
      FORCE:  stateNext = NORMAL;
    endcase
  end

  // Registered write port; address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfWe   <= 1'b0;
      rfReg  <= '0;
      rfData <= '0;
    end else begin
      rfWe <= pipeGrant || headGrant;
      if (pipeGrant) begin
        rfReg  <= bus.pipe_reg;
        rfData <= bus.pipe_data;
      end else if (headGrant) begin
        rfReg  <= headEntry.regIdx;
        rfData <= headEntry.data;
      end
    end
  end

  // Pending-write mask from the registered FIFO contents.
  always_comb begin
    pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) pendMask = pendMask | regOneHot(entryReg[i]);
    end
  end

  assign bus.late_ready = (fifoCount < DEPTH_CNT);
  assign bus.empty      = fifoEmpty;
  assign bus.pend_mask  = pendMask;
  assign bus.pipe_stall = (state == FORCE);
  assign bus.rf_we      = rfWe;
  assign bus.rf_reg     = rfReg;
  assign bus.rf_data    = rfData;

endmodule
